game_collision_scanner: RTL and testbench

- Time-multiplexed, parametrised collision engine for the shooter game core.
- Once per frame it snapshots every object position and valid mask.
- It then walks all relevant pairs through a single AABB comparator, one pair per clock, and publishes registered per-object hit masks with a done pulse.
- It replaces the all-parallel comparator array: far less logic, scales with object counts, and ignores dead objects.

---
 rtl/game_collision_pkg.sv | 29 ++
 rtl/collision_aabb_cmp.sv | 37 +++
 rtl/game_collision_scanner.sv | 243 ++++++++++++++++++++++++
 tb/tb_game_collision_scanner.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_collision_pkg.sv
// Shared types and default object geometry for the time-multiplexed collision scanner.
package game_collision_pkg;

  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 9;
  localparam int POS_W   = X_W_DEF + Y_W_DEF;

  localparam int BULLET_W_DEF = 4;
  localparam int BULLET_H_DEF = 8;
  localparam int ENEMY_W_DEF  = 32;
  localparam int ENEMY_H_DEF  = 24;
  localparam int PLAYER_W_DEF = 32;
  localparam int PLAYER_H_DEF = 16;
  localparam int PLAYER_Y_DEF = 440;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
  } pos_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PH_BB = 3'd1,
    PH_PE = 3'd2,
    PH_EP = 3'd3,
    DONE  = 3'd4
  } phase_e;

endpackage

// File: rtl/collision_aabb_cmp.sv
// Combinational AABB overlap test; right/bottom edges are one bit wider so edge objects never wrap.
// Zero latency, no flow control; touching edges do not count as overlap.
module collision_aabb_cmp #(
  parameter int X_W = 10,
  parameter int Y_W = 9
) (
  input  logic           i_AValid,
  input  logic [X_W-1:0] i_AX,
  input  logic [Y_W-1:0] i_AY,
  input  logic [X_W-1:0] i_AW,
  input  logic [Y_W-1:0] i_AH,
  input  logic           i_BValid,
  input  logic [X_W-1:0] i_BX,
  input  logic [Y_W-1:0] i_BY,
  input  logic [X_W-1:0] i_BW,
  input  logic [Y_W-1:0] i_BH,
  output logic           o_Hit
);

  logic [X_W:0] w_AX1, w_AX2, w_BX1, w_BX2;
  logic [Y_W:0] w_AY1, w_AY2, w_BY1, w_BY2;
  logic         w_XOvl, w_YOvl;

  assign w_AX1 = {1'b0, i_AX};
  assign w_AX2 = w_AX1 + {1'b0, i_AW};
  assign w_BX1 = {1'b0, i_BX};
  assign w_BX2 = w_BX1 + {1'b0, i_BW};
  assign w_AY1 = {1'b0, i_AY};
  assign w_AY2 = w_AY1 + {1'b0, i_AH};
  assign w_BY1 = {1'b0, i_BY};
  assign w_BY2 = w_BY1 + {1'b0, i_BH};

  assign w_XOvl = !((w_AX2 <= w_BX1) || (w_AX1 >= w_BX2));
  assign w_YOvl = !((w_AY2 <= w_BY1) || (w_AY1 >= w_BY2));
  assign o_Hit  = i_AValid & i_BValid & w_XOvl & w_YOvl;

endmodule

// File: rtl/game_collision_scanner.sv
// Per-frame collision scan, one object pair per clock through a shared comparator; o_Done 73 cycles after start with defaults.
// Starts while busy are dropped; COLLISION_OVERRUN_EN adds a sticky o_Overrun flag with i_OverrunClr.
module game_collision_scanner
  import game_collision_pkg::*;
#(
  parameter int N_ENEMY   = 8,
  parameter int N_EBULLET = 8,
  parameter int N_PBULLET = 4,
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int BULLET_W  = BULLET_W_DEF,
  parameter int BULLET_H  = BULLET_H_DEF,
  parameter int ENEMY_W   = ENEMY_W_DEF,
  parameter int ENEMY_H   = ENEMY_H_DEF,
  parameter int PLAYER_W  = PLAYER_W_DEF,
  parameter int PLAYER_H  = PLAYER_H_DEF,
  parameter int PLAYER_Y  = PLAYER_Y_DEF
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_n,
  input  logic                           i_Start,
  input  logic [N_ENEMY*(X_W+Y_W)-1:0]   i_EnemyPos,
  input  logic [N_EBULLET*(X_W+Y_W)-1:0] i_EBulletPos,
  input  logic [N_PBULLET*(X_W+Y_W)-1:0] i_PBulletPos,
  input  logic [X_W-1:0]                 i_PlayerX,
  input  logic [N_ENEMY-1:0]             i_EnemyValid,
  input  logic [N_EBULLET-1:0]           i_EBulletValid,
  input  logic [N_PBULLET-1:0]           i_PBulletValid,
`ifdef COLLISION_OVERRUN_EN
  input  logic                           i_OverrunClr,
  output logic                           o_Overrun,
`endif
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic [N_ENEMY-1:0]             o_EnemyHit,
  output logic [N_EBULLET-1:0]           o_EBulletHit,
  output logic [N_PBULLET-1:0]           o_PBulletHit,
  output logic                           o_PlayerHit
);

  localparam int P_W   = X_W + Y_W;
  localparam int N_BB  = N_EBULLET * N_PBULLET;
  localparam int N_PE  = N_PBULLET * N_ENEMY;
  localparam int N_EP  = N_EBULLET;
  localparam int N_M1  = (N_ENEMY > N_EBULLET) ? N_ENEMY : N_EBULLET;
  localparam int N_MAX = (N_M1 > N_PBULLET) ? N_M1 : N_PBULLET;
  localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

  phase_e r_State, w_NextState;

  logic [N_ENEMY*P_W-1:0]   r_EnPos;
  logic [N_EBULLET*P_W-1:0] r_EbPos;
  logic [N_PBULLET*P_W-1:0] r_PbPos;
  logic [X_W-1:0]           r_PlayerX;
  logic [N_ENEMY-1:0]       r_EnValid, r_EnAcc, w_EnAccNxt, r_EnemyHit;
  logic [N_EBULLET-1:0]     r_EbValid, r_EbAcc, w_EbAccNxt, r_EBulletHit;
  logic [N_PBULLET-1:0]     r_PbValid, r_PbAcc, w_PbAccNxt, r_PBulletHit;
  logic                     r_PlAcc, w_PlAccNxt, r_PlayerHit, r_Done;
  logic [CNT_W-1:0]         r_Outer, r_Inner;

  logic [P_W-1:0] w_EbOut, w_PbIn, w_PbOut, w_EnIn;
  logic           w_EbOutV, w_PbInV, w_PbOutV, w_EnInV;
  logic [X_W-1:0] w_AX, w_AW, w_BX, w_BW;
  logic [Y_W-1:0] w_AY, w_AH, w_BY, w_BH;
  logic           w_AV, w_BV, w_Hit, w_InLast, w_OutLast, w_Scan;

  // Current-pair object fetch: outer index picks A, inner index picks B.
  always_comb begin
    w_EbOut = '0; w_EbOutV = 1'b0;
    w_PbOut = '0; w_PbOutV = 1'b0;
    w_PbIn  = '0; w_PbInV  = 1'b0;
    w_EnIn  = '0; w_EnInV  = 1'b0;
    for (int i = 0; i < N_EBULLET; i++) begin
      if (r_Outer == CNT_W'(i)) begin
        w_EbOut  = r_EbPos[i*P_W +: P_W];
        w_EbOutV = r_EbValid[i];
      end
    end
    for (int i = 0; i < N_PBULLET; i++) begin
      if (r_Outer == CNT_W'(i)) begin
        w_PbOut  = r_PbPos[i*P_W +: P_W];
        w_PbOutV = r_PbValid[i];
      end
      if (r_Inner == CNT_W'(i)) begin
        w_PbIn  = r_PbPos[i*P_W +: P_W];
        w_PbInV = r_PbValid[i];
      end
    end
    for (int i = 0; i < N_ENEMY; i++) begin
      if (r_Inner == CNT_W'(i)) begin
        w_EnIn  = r_EnPos[i*P_W +: P_W];
        w_EnInV = r_EnValid[i];
      end
    end
  end

  always_comb begin
    w_AV = 1'b0; w_AX = '0; w_AY = '0; w_AW = '0; w_AH = '0;
    w_BV = 1'b0; w_BX = '0; w_BY = '0; w_BW = '0; w_BH = '0;
    w_InLast  = 1'b1;
    w_OutLast = 1'b1;
    case (r_State)
      PH_BB: begin
        w_AV = w_EbOutV; w_AX = w_EbOut[P_W-1:Y_W]; w_AY = w_EbOut[Y_W-1:0];
        w_AW = X_W'(BULLET_W); w_AH = Y_W'(BULLET_H);
        w_BV = w_PbInV; w_BX = w_PbIn[P_W-1:Y_W]; w_BY = w_PbIn[Y_W-1:0];
        w_BW = X_W'(BULLET_W); w_BH = Y_W'(BULLET_H);
        w_InLast  = (r_Inner == CNT_W'(N_PBULLET - 1));
        w_OutLast = (r_Outer == CNT_W'(N_EBULLET - 1));
      end
      PH_PE: begin
        w_AV = w_PbOutV; w_AX = w_PbOut[P_W-1:Y_W]; w_AY = w_PbOut[Y_W-1:0];
        w_AW = X_W'(BULLET_W); w_AH = Y_W'(BULLET_H);
        w_BV = w_EnInV; w_BX = w_EnIn[P_W-1:Y_W]; w_BY = w_EnIn[Y_W-1:0];
        w_BW = X_W'(ENEMY_W); w_BH = Y_W'(ENEMY_H);
        w_InLast  = (r_Inner == CNT_W'(N_ENEMY - 1));
        w_OutLast = (r_Outer == CNT_W'(N_PBULLET - 1));
      end
      PH_EP: begin
        w_AV = w_EbOutV; w_AX = w_EbOut[P_W-1:Y_W]; w_AY = w_EbOut[Y_W-1:0];
        w_AW = X_W'(BULLET_W); w_AH = Y_W'(BULLET_H);
        w_BV = 1'b1; w_BX = r_PlayerX; w_BY = Y_W'(PLAYER_Y);
        w_BW = X_W'(PLAYER_W); w_BH = Y_W'(PLAYER_H);
        w_InLast  = 1'b1;
        w_OutLast = (r_Outer == CNT_W'(N_EBULLET - 1));
      end
      default: ;
    endcase
  end

  collision_aabb_cmp #(.X_W(X_W), .Y_W(Y_W)) u_cmp (
    .i_AValid(w_AV), .i_AX(w_AX), .i_AY(w_AY), .i_AW(w_AW), .i_AH(w_AH),
    .i_BValid(w_BV), .i_BX(w_BX), .i_BY(w_BY), .i_BW(w_BW), .i_BH(w_BH),
    .o_Hit(w_Hit)
  );

  assign w_Scan = (r_State == PH_BB) || (r_State == PH_PE) || (r_State == PH_EP);

  always_comb begin
    w_EnAccNxt = r_EnAcc;
    w_EbAccNxt = r_EbAcc;
    w_PbAccNxt = r_PbAcc;
    w_PlAccNxt = r_PlAcc | (w_Hit && r_State == PH_EP);
    for (int i = 0; i < N_EBULLET; i++)
      if (w_Hit && (r_State == PH_BB || r_State == PH_EP) && r_Outer == CNT_W'(i))
        w_EbAccNxt[i] = 1'b1;
    for (int i = 0; i < N_PBULLET; i++)
      if (w_Hit && ((r_State == PH_BB && r_Inner == CNT_W'(i)) ||
                    (r_State == PH_PE && r_Outer == CNT_W'(i))))
        w_PbAccNxt[i] = 1'b1;
    for (int i = 0; i < N_ENEMY; i++)
      if (w_Hit && r_State == PH_PE && r_Inner == CNT_W'(i))
        w_EnAccNxt[i] = 1'b1;
  end

  // Empty phases are skipped by elaboration-time pair counts.
  always_comb begin
    w_NextState = r_State;
    case (r_State)
      IDLE:
        if (i_Start)
          w_NextState = (N_BB > 0) ? PH_BB : (N_PE > 0) ? PH_PE : (N_EP > 0) ? PH_EP : DONE;
      PH_BB:
        if (w_InLast && w_OutLast)
          w_NextState = (N_PE > 0) ? PH_PE : (N_EP > 0) ? PH_EP : DONE;
      PH_PE:
        if (w_InLast && w_OutLast)
          w_NextState = (N_EP > 0) ? PH_EP : DONE;
      PH_EP:
        if (w_InLast && w_OutLast)
          w_NextState = DONE;
      DONE:    w_NextState = IDLE;
      default: w_NextState = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) r_State <= IDLE;
    else          r_State <= w_NextState;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_EnPos <= '0; r_EbPos <= '0; r_PbPos <= '0; r_PlayerX <= '0;
      r_EnValid <= '0; r_EbValid <= '0; r_PbValid <= '0;
      r_EnAcc <= '0; r_EbAcc <= '0; r_PbAcc <= '0; r_PlAcc <= 1'b0;
      r_Outer <= '0; r_Inner <= '0;
      r_EnemyHit <= '0; r_EBulletHit <= '0; r_PBulletHit <= '0; r_PlayerHit <= 1'b0;
      r_Done <= 1'b0;
    end else begin
      r_Done <= (w_NextState == DONE);
      if (r_State == IDLE && i_Start) begin
        r_EnPos   <= i_EnemyPos;
        r_EbPos   <= i_EBulletPos;
        r_PbPos   <= i_PBulletPos;
        r_PlayerX <= i_PlayerX;
        r_EnValid <= i_EnemyValid;
        r_EbValid <= i_EBulletValid;
        r_PbValid <= i_PBulletValid;
        r_EnAcc <= '0; r_EbAcc <= '0; r_PbAcc <= '0; r_PlAcc <= 1'b0;
        r_Outer <= '0; r_Inner <= '0;
      end else if (w_Scan) begin
        r_EnAcc <= w_EnAccNxt; r_EbAcc <= w_EbAccNxt;
        r_PbAcc <= w_PbAccNxt; r_PlAcc <= w_PlAccNxt;
        if (w_InLast) begin
          r_Inner <= '0;
          r_Outer <= w_OutLast ? '0 : r_Outer + CNT_W'(1);
        end else begin
          r_Inner <= r_Inner + CNT_W'(1);
        end
      end
      // Publish at the edge entering DONE so the final pair is included.
      if (w_NextState == DONE && r_State != DONE) begin
        if (r_State == IDLE) begin
          r_EnemyHit <= '0; r_EBulletHit <= '0; r_PBulletHit <= '0; r_PlayerHit <= 1'b0;
        end else begin
          r_EnemyHit   <= w_EnAccNxt;
          r_EBulletHit <= w_EbAccNxt;
          r_PBulletHit <= w_PbAccNxt;
          r_PlayerHit  <= w_PlAccNxt;
        end
      end
    end
  end

`ifdef COLLISION_OVERRUN_EN
  logic r_Overrun;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)                          r_Overrun <= 1'b0;
    else if (i_OverrunClr)                 r_Overrun <= 1'b0;
    else if (i_Start && r_State != IDLE)   r_Overrun <= 1'b1;
  end
  assign o_Overrun = r_Overrun;
`endif

  assign o_Busy       = (r_State != IDLE);
  assign o_Done       = r_Done;
  assign o_EnemyHit   = r_EnemyHit;
  assign o_EBulletHit = r_EBulletHit;
  assign o_PBulletHit = r_PBulletHit;
  assign o_PlayerHit  = r_PlayerHit;

endmodule

// File: tb/tb_game_collision_scanner.sv
// Directed bench for game_collision_scanner: expectations queued at start, checked by a monitor on o_Done.
module tb_game_collision_scanner;
  import game_collision_pkg::*;

  localparam int NE = 8, NEB = 8, NPB = 4, PW = 19;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [NE*PW-1:0]  en_pos;
  logic [NEB*PW-1:0] eb_pos;
  logic [NPB*PW-1:0] pb_pos;
  logic [9:0]        player_x;
  logic [NE-1:0]     en_v;
  logic [NEB-1:0]    eb_v;
  logic [NPB-1:0]    pb_v;
  logic              busy, done, pl_hit;
  logic [NE-1:0]     en_hit;
  logic [NEB-1:0]    eb_hit;
  logic [NPB-1:0]    pb_hit;
`ifdef COLLISION_OVERRUN_EN
  logic ovr_clr = 1'b0, overrun;
`endif

  game_collision_scanner dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start),
    .i_EnemyPos(en_pos), .i_EBulletPos(eb_pos), .i_PBulletPos(pb_pos),
    .i_PlayerX(player_x),
    .i_EnemyValid(en_v), .i_EBulletValid(eb_v), .i_PBulletValid(pb_v),
`ifdef COLLISION_OVERRUN_EN
    .i_OverrunClr(ovr_clr), .o_Overrun(overrun),
`endif
    .o_Busy(busy), .o_Done(done),
    .o_EnemyHit(en_hit), .o_EBulletHit(eb_hit), .o_PBulletHit(pb_hit),
    .o_PlayerHit(pl_hit)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] en;
    logic [7:0] eb;
    logic [3:0] pb;
    logic       pl;
    int         at;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clear_all();
    en_pos = '0; eb_pos = '0; pb_pos = '0;
    en_v = '0; eb_v = '0; pb_v = '0; player_x = '0;
  endtask

  task automatic set_en(int i, int x, int y);
    pos_t p; p.x = 10'(x); p.y = 9'(y);
    en_pos[i*PW +: PW] = p; en_v[i] = 1'b1;
  endtask
  task automatic set_eb(int i, int x, int y);
    pos_t p; p.x = 10'(x); p.y = 9'(y);
    eb_pos[i*PW +: PW] = p; eb_v[i] = 1'b1;
  endtask
  task automatic set_pb(int i, int x, int y);
    pos_t p; p.x = 10'(x); p.y = 9'(y);
    pb_pos[i*PW +: PW] = p; pb_v[i] = 1'b1;
  endtask

  // Start accepted at the edge after start is raised; o_Done is due 73 edges later.
  task automatic start_scan(logic [7:0] e_en, logic [7:0] e_eb, logic [3:0] e_pb, logic e_pl);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1;
    e.en = e_en; e.eb = e_eb; e.pb = e_pb; e.pl = e_pl; e.at = cyc + 73;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_idle(string nm);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=pending required=done", nm);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] pub_en = '0, pub_eb = '0;
  logic [3:0] pub_pb = '0;
  logic       pub_pl = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pub_en = '0; pub_eb = '0; pub_pb = '0; pub_pl = 1'b0;
      chk("reset_outputs", {9'd0, busy, done, en_hit, eb_hit, pb_hit, pl_hit}, 32'd0);
    end else if (done) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done actual=done required=no_done (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.at);
        chk("enemy_hit", {24'd0, en_hit}, {24'd0, e.en});
        chk("ebullet_hit", {24'd0, eb_hit}, {24'd0, e.eb});
        chk("pbullet_hit", {28'd0, pb_hit}, {28'd0, e.pb});
        chk("player_hit", {31'd0, pl_hit}, {31'd0, e.pl});
        chk("busy_in_done", {31'd0, busy}, 32'd1);
        pub_en = e.en; pub_eb = e.eb; pub_pb = e.pb; pub_pl = e.pl;
      end
    end else begin
      chk("hold_outputs", {11'd0, en_hit, eb_hit, pb_hit, pl_hit},
          {11'd0, pub_en, pub_eb, pub_pb, pub_pl});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear_all();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    // Player bullet inside an enemy box.
    clear_all(); set_pb(0, 100, 200); set_en(3, 90, 190);
    start_scan(8'h08, 8'h00, 4'h1, 1'b0);
    wait_idle("pb_enemy");

    // Bullets touching on x, then overlapping by one pixel.
    clear_all(); set_eb(0, 100, 200); set_pb(0, 104, 200);
    start_scan(8'h00, 8'h00, 4'h0, 1'b0);
    wait_idle("bb_touch");
    set_pb(0, 103, 200);
    start_scan(8'h00, 8'h01, 4'h1, 1'b0);
    wait_idle("bb_overlap");

    // Enemy bullet on the player, then the same bullet dead.
    clear_all(); player_x = 10'd300; set_eb(5, 310, 445);
    start_scan(8'h00, 8'h20, 4'h0, 1'b1);
    wait_idle("eb_player");
    eb_v[5] = 1'b0;
    start_scan(8'h00, 8'h00, 4'h0, 1'b0);
    wait_idle("eb_dead");

    // Enemy at the right screen edge must not wrap onto a bullet at x=2.
    clear_all(); set_en(0, 1020, 100); set_pb(0, 2, 100);
    start_scan(8'h00, 8'h00, 4'h0, 1'b0);
    wait_idle("edge_wrap");

    // Starts mid-scan and in the DONE cycle are ignored; input changes mid-scan have no effect.
    clear_all(); set_pb(0, 100, 200); set_en(3, 90, 190);
    start_scan(8'h08, 8'h00, 4'h1, 1'b0);
    repeat (38) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 clear_all(); set_en(0, 100, 200); en_v = 8'hFF;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk); n++;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("restart_ignored");
    repeat (100) @(negedge clk);
    chk("idle_after_ignored_start", {31'd0, busy}, 32'd0);
`ifdef COLLISION_OVERRUN_EN
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1 ovr_clr = 1'b1;
    @(posedge clk); #1 ovr_clr = 1'b0;
    chk("overrun_cleared", {31'd0, overrun}, 32'd0);
    clear_all(); set_pb(0, 100, 200); set_en(3, 90, 190);
    start_scan(8'h08, 8'h00, 4'h1, 1'b0);
    repeat (10) @(posedge clk);
    #1 start = 1'b1; ovr_clr = 1'b1;
    @(posedge clk); #1 start = 1'b0; ovr_clr = 1'b0;
    chk("overrun_clear_wins", {31'd0, overrun}, 32'd0);
    wait_idle("overrun_clr_scan");
`endif

    // Reset mid-scan aborts without o_Done; next scan completes normally.
    clear_all(); player_x = 10'd300; set_eb(5, 310, 445);
    start_scan(8'h00, 8'h20, 4'h0, 1'b1);
    repeat (29) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1 chk("abort_clears", {9'd0, busy, done, en_hit, eb_hit, pb_hit, pl_hit}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_after_abort", {31'd0, busy}, 32'd0);
`ifdef COLLISION_OVERRUN_EN
    chk("overrun_after_reset", {31'd0, overrun}, 32'd0);
`endif
    start_scan(8'h00, 8'h20, 4'h0, 1'b1);
    wait_idle("after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
